// File: rtl/base_alast_fifo.sv
// Lossy always-ready ring buffer of depth words; keep-newest (mode 0) or keep-oldest (mode 1) on overflow.
// Latency: 1 cycle, no bypass. Never back-pressures; drops a word when full and stalled. Drop counter under BASE_ALAST_FIFO_DROPCNT_EN.
module base_alast_fifo #(
  parameter int width = 1,
  parameter int depth = 4,
  parameter int mode  = 0
`ifdef BASE_ALAST_FIFO_DROPCNT_EN
  , parameter int dcw = 16
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       i_r,
  input  logic                       i_v,
  input  logic [width-1:0]           i_d,
  input  logic                       o_r,
  output logic                       o_v,
  output logic [width-1:0]           o_d,
  output logic [$clog2(depth+1)-1:0] o_cnt,
  output logic                       o_drop
`ifdef BASE_ALAST_FIFO_DROPCNT_EN
  , output logic [dcw-1:0]           o_dropcnt
`endif
);

  localparam int CW = $clog2(depth + 1);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    rp, wp;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             full, push, pop;
  logic             do_wr, adv_wp, adv_rp, drop_nxt;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign i_r   = 1'b1;
  assign o_v   = (cnt != '0);
  assign o_d   = o_v ? mem[rp] : '0;
  assign o_cnt = cnt;
  assign full  = (cnt == CW'(depth));
  assign push  = i_v;
  assign pop   = o_v & o_r;

  always_comb begin
    do_wr    = 1'b0;
    adv_wp   = 1'b0;
    adv_rp   = 1'b0;
    drop_nxt = 1'b0;
    cnt_nxt  = cnt;
    if (push && (!full || pop || mode == 0)) begin
      do_wr  = 1'b1;
      adv_wp = 1'b1;
    end
    if (pop)
      adv_rp = 1'b1;
    // Full and stalled: mode 0 evicts the head, mode 1 discards the incoming word.
    if (push && full && !pop) begin
      drop_nxt = 1'b1;
      if (mode == 0)
        adv_rp = 1'b1;
    end
    if (push && !pop && !full)
      cnt_nxt = cnt + CW'(1);
    else if (pop && !push)
      cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rp     <= '0;
      wp     <= '0;
      cnt    <= '0;
      o_drop <= 1'b0;
    end else begin
      if (adv_rp) rp <= ptr_inc(rp);
      if (adv_wp) wp <= ptr_inc(wp);
      cnt    <= cnt_nxt;
      o_drop <= drop_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_wr)
      mem[wp] <= i_d;
  end

`ifdef BASE_ALAST_FIFO_DROPCNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      o_dropcnt <= '0;
    else if (drop_nxt && !(&o_dropcnt))
      o_dropcnt <= o_dropcnt + dcw'(1);
  end
`endif

endmodule
